// File: rtl/counter_seq_ctrl.sv
// Wishbone-mapped sequencer for an external up-counter datapath: prescaled
// inc/clr strobes, compare match, one-shot or periodic runs, sticky match irq.
module counter_seq_ctrl #(
  parameter int BITS    = 32,
  parameter int PS_BITS = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] cnt_value,
  output logic            cnt_inc,
  output logic            cnt_clr,
  output logic            cnt_load,
  output logic [BITS-1:0] cnt_load_val,
  output logic            irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE_ST = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic [2:0]         r_ctrl;          // {IRQ_EN, PERIODIC, EN}
  logic [PS_BITS-1:0] r_prescale, r_ps, w_ps_nxt;
  logic [BITS-1:0]    r_compare;
  logic               r_match, r_done, r_irq;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    return res;
  endfunction

  logic               w_valid, w_wr, w_wr_ctrl, w_wr_ps, w_wr_cmp, w_wr_status, w_load;
  logic               w_en_on, w_en_off, w_tick, w_hit, w_inc, w_clr, w_set_done;
  logic [2:0]         w_idx, w_ctrl_m;
  logic [PS_BITS-1:0] w_ps_m;
  logic [BITS-1:0]    w_cmp_m, w_load_m;
  logic [31:0]        w_rdata;
  logic               w_unused_adr;

  assign w_valid     = wbs_cyc_i & wbs_stb_i;
  assign w_wr        = w_valid & r_ack & wbs_we_i;
  assign w_idx       = wbs_adr_i[4:2];
  assign w_wr_ctrl   = w_wr & (w_idx == 3'd0);
  assign w_wr_ps     = w_wr & (w_idx == 3'd1);
  assign w_wr_cmp    = w_wr & (w_idx == 3'd2);
  assign w_load      = w_wr & (w_idx == 3'd3);
  assign w_wr_status = w_wr & (w_idx == 3'd4);

  // EN only counts as written when its byte lane is selected.
  assign w_en_on  = w_wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
  assign w_en_off = w_wr_ctrl & wbs_sel_i[0] & ~wbs_dat_i[0];

  assign w_ctrl_m = 3'(f_merge(32'(r_ctrl), wbs_dat_i, wbs_sel_i));
  assign w_ps_m   = PS_BITS'(f_merge(32'(r_prescale), wbs_dat_i, wbs_sel_i));
  assign w_cmp_m  = BITS'(f_merge(32'(r_compare), wbs_dat_i, wbs_sel_i));
  assign w_load_m = BITS'(f_merge(32'(cnt_value), wbs_dat_i, wbs_sel_i));

  // A load on a tick cycle pre-empts that tick's compare and strobe.
  assign w_tick = (r_state == RUN) && (r_ps == '0);
  assign w_hit  = w_tick & ~w_load & (cnt_value == r_compare);

  assign w_unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_ps_nxt    = r_ps;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      IDLE, DONE_ST: begin
        if (w_en_on) begin
          w_state_nxt = RUN;
          w_ps_nxt    = r_prescale;
        end
      end
      RUN: begin
        if (w_tick) begin
          w_ps_nxt = r_prescale;
          if (w_hit) begin
            if (r_ctrl[1]) begin
              w_clr = 1'b1;
            end else begin
              w_state_nxt = DONE_ST;
              w_set_done  = 1'b1;
            end
          end else if (!w_load) begin
            w_inc = 1'b1;
          end
        end else begin
          w_ps_nxt = r_ps - PS_BITS'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_en_off) begin
      w_state_nxt = IDLE;
      w_ps_nxt    = '0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0:    w_rdata[2:0] = r_ctrl;
      3'd1:    w_rdata      = 32'(r_prescale);
      3'd2:    w_rdata      = 32'(r_compare);
      3'd3:    w_rdata      = 32'(cnt_value);
      3'd4:    w_rdata[2:0] = {r_done, (r_state == RUN), r_match};
      default: w_rdata      = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_ps       <= '0;
      r_compare  <= '0;
      r_match    <= 1'b0;
      r_done     <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_ps    <= w_ps_nxt;
      r_ack   <= w_valid & ~r_ack;
      r_dat   <= (w_valid & ~r_ack & ~wbs_we_i) ? w_rdata : '0;
      if (w_wr_ctrl) r_ctrl     <= w_ctrl_m;
      if (w_wr_ps)   r_prescale <= w_ps_m;
      if (w_wr_cmp)  r_compare  <= w_cmp_m;
      // A new match wins over a same-cycle write-1-to-clear.
      r_match <= w_hit | (r_match & ~(w_wr_status & wbs_sel_i[0] & wbs_dat_i[0]));
      r_done  <= w_set_done | (r_done & ~(w_wr_status & wbs_sel_i[0] & wbs_dat_i[2]));
      r_irq   <= r_match & r_ctrl[2];
    end
  end

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign cnt_inc      = w_inc;
  assign cnt_clr      = w_clr;
  assign cnt_load     = w_load;
  assign cnt_load_val = w_load ? w_load_m : '0;
  assign irq          = r_irq;

endmodule
